// File: rtl/rvfi_unique_multi_check.sv
// rvfi_unique_multi_check: flags any rvfi_order retiring more than once among up to DEPTH tracked orders.
// Define RVFI_UNIQUE_ROLLBACK_EN for rollback ports; FORMAL enables the assume/assert properties.
module rvfi_unique_multi_check #(
   parameter int NRET    = 1,
   parameter int DEPTH   = 4,
   parameter int ORDER_W = 64,
   parameter int TRIG_CH = 0
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic                                        trig,
   input  logic                                        check,
   input  logic [NRET-1:0]                             rvfi_valid,
   input  logic [ORDER_W*NRET-1:0]                     rvfi_order,
`ifdef RVFI_UNIQUE_ROLLBACK_EN
   input  logic                                        rvfi_rollback_valid,
   input  logic [ORDER_W-1:0]                          rvfi_rollback_order,
`endif
   output logic [$clog2(DEPTH+1)-1:0]                  occupancy,
   output logic                                        full,
   output logic                                        dup_err,
   output logic [(DEPTH > 1 ? $clog2(DEPTH) : 1)-1:0]  dup_slot
);
   localparam int OCC_W  = $clog2(DEPTH+1);
   localparam int SLOT_W = DEPTH > 1 ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0]   slot_vld_q, slot_vld_d, slot_seen_q, slot_seen_d;
   logic [ORDER_W-1:0] slot_order_q [DEPTH];
   logic [ORDER_W-1:0] slot_order_d [DEPTH];
   logic               dup_err_q, dup_err_d;
   logic [SLOT_W-1:0]  dup_slot_q, dup_slot_d;
   logic [DEPTH-1:0]   rb_kill, live, hit;
   logic [ORDER_W-1:0] trig_order;
   logic               held, other, placed;

   assign trig_order = rvfi_order[ORDER_W*TRIG_CH +: ORDER_W];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef RVFI_UNIQUE_ROLLBACK_EN
         rb_kill[i] = rvfi_rollback_valid && slot_order_q[i] >= rvfi_rollback_order;
`else
         rb_kill[i] = 1'b0;
`endif
      end
   end

   // Rollback invalidates first, so matches and capture only see the surviving slots.
   always_comb begin
      live         = slot_vld_q & ~rb_kill;
      hit          = slot_vld_q & slot_seen_q;
      slot_vld_d   = live;
      slot_seen_d  = slot_seen_q & ~rb_kill;
      slot_order_d = slot_order_q;
      held         = 1'b0;
      other        = 1'b0;
      placed       = 1'b0;
      dup_err_d    = dup_err_q | (check & |hit);
      dup_slot_d   = dup_slot_q;
      for (int c = 0; c < NRET; c++)
         if (c != TRIG_CH && rvfi_valid[c] && rvfi_order[ORDER_W*c +: ORDER_W] == trig_order) other = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         for (int c = 0; c < NRET; c++)
            if (live[i] && rvfi_valid[c] && rvfi_order[ORDER_W*c +: ORDER_W] == slot_order_q[i])
               slot_seen_d[i] = 1'b1;
         if (live[i] && slot_order_q[i] == trig_order) held = 1'b1;
      end
      for (int i = 0; i < DEPTH; i++)
         if (trig && rvfi_valid[TRIG_CH] && !held && !placed && !live[i]) begin
            placed          = 1'b1;
            slot_vld_d[i]   = 1'b1;
            slot_order_d[i] = trig_order;
            slot_seen_d[i]  = other;
         end
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!dup_err_q && check && hit[i]) dup_slot_d = SLOT_W'(i);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         slot_vld_q   <= '0;
         slot_seen_q  <= '0;
         slot_order_q <= '{default: '0};
         dup_err_q    <= 1'b0;
         dup_slot_q   <= '0;
      end else begin
         slot_vld_q   <= slot_vld_d;
         slot_seen_q  <= slot_seen_d;
         slot_order_q <= slot_order_d;
         dup_err_q    <= dup_err_d;
         dup_slot_q   <= dup_slot_d;
      end
   end

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(slot_vld_q[i]);
   end

   assign full     = occupancy == OCC_W'(DEPTH);
   assign dup_err  = dup_err_q;
   assign dup_slot = dup_slot_q;

`ifdef FORMAL
   always_comb begin
      if (!reset) begin
         if (trig) assume (rvfi_valid[TRIG_CH]);
         if (trig && rvfi_valid[TRIG_CH]) assume (!full || held);
         for (int i = 0; i < DEPTH; i++) assert (!(check && slot_vld_q[i] && slot_seen_q[i]));
      end
   end
`endif
endmodule

// File: tb/tb_rvfi_unique_multi_check.sv
// tb_rvfi_unique_multi_check: directed scenarios plus randomized traffic against a slot-table reference model.
module tb_rvfi_unique_multi_check;
   localparam int NRET = 2, DEPTH = 4, OW = 16;

   logic clock = 1'b0, reset, trig, check;
   logic [NRET-1:0] rvfi_valid;
   logic [OW*NRET-1:0] rvfi_order;
   logic rb_v;
   logic [OW-1:0] rb_o;
   logic [2:0] occupancy;
   logic full, dup_err;
   logic [1:0] dup_slot;

   int checks = 0, errors = 0;
   bit m_vld[DEPTH];
   bit m_seen[DEPTH];
   logic [OW-1:0] m_ord[DEPTH];
   bit m_err;
   int m_slot;

   rvfi_unique_multi_check #(.NRET(NRET), .DEPTH(DEPTH), .ORDER_W(OW), .TRIG_CH(0)) dut (
      .clock(clock), .reset(reset), .trig(trig), .check(check),
      .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
`ifdef RVFI_UNIQUE_ROLLBACK_EN
      .rvfi_rollback_valid(rb_v), .rvfi_rollback_order(rb_o),
`endif
      .occupancy(occupancy), .full(full), .dup_err(dup_err), .dup_slot(dup_slot));

   always #5 clock = ~clock;

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_vld[i] = 0;
         m_seen[i] = 0;
         m_ord[i] = '0;
      end
      m_err = 0;
      m_slot = 0;
   endtask

   task automatic cyc(input logic t, input logic ck, input logic [1:0] v, input logic [OW-1:0] o0,
                      input logic [OW-1:0] o1, input logic rv, input logic [OW-1:0] ro);
      bit found;
      logic [OW-1:0] oc;
      trig = t; check = ck; rvfi_valid = v; rvfi_order = {o1, o0}; rb_v = rv; rb_o = ro;
      if (ck && !m_err)
         for (int i = 0; i < DEPTH; i++)
            if (m_vld[i] && m_seen[i]) begin
               m_err = 1;
               m_slot = i;
               break;
            end
      if (rv)
         for (int i = 0; i < DEPTH; i++)
            if (m_vld[i] && m_ord[i] >= ro) begin
               m_vld[i] = 0;
               m_seen[i] = 0;
            end
      for (int c = 0; c < NRET; c++) begin
         oc = c == 0 ? o0 : o1;
         if (v[c])
            for (int i = 0; i < DEPTH; i++)
               if (m_vld[i] && m_ord[i] == oc) m_seen[i] = 1;
      end
      if (t && v[0]) begin
         found = 0;
         for (int i = 0; i < DEPTH; i++) if (m_vld[i] && m_ord[i] == o0) found = 1;
         if (!found)
            for (int i = 0; i < DEPTH; i++)
               if (!m_vld[i]) begin
                  m_vld[i] = 1;
                  m_ord[i] = o0;
                  m_seen[i] = v[1] && o1 == o0;
                  break;
               end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      cyc(0, 0, 2'b00, 0, 0, 0, 0);
   endtask

   task automatic rst();
      reset = 1;
      idle();
      model_clear();
      reset = 0;
   endtask

   task automatic test_reset();
      rst();
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", full); end
      checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL reset_dup_err: got %0b want 0", dup_err); end
      checks++; if (dup_slot !== 2'd0) begin errors++; $display("FAIL reset_dup_slot: got %0d want 0", dup_slot); end
   endtask

   task automatic test_single_dup();
      rst();
      cyc(1, 0, 2'b01, 5, 0, 0, 0);
      checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL single_occ: got %0d want 1", occupancy); end
      idle(); idle();
      cyc(0, 0, 2'b01, 5, 0, 0, 0);
      checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL single_no_check: got %0b want 0", dup_err); end
      cyc(0, 1, 2'b00, 0, 0, 0, 0);
      checks++; if (dup_err !== 1'b1) begin errors++; $display("FAIL single_dup_err: got %0b want 1", dup_err); end
      checks++; if (dup_slot !== 2'd0) begin errors++; $display("FAIL single_dup_slot: got %0d want 0", dup_slot); end
   endtask

   task automatic test_concurrent();
      rst();
      cyc(1, 1, 2'b11, 7, 7, 0, 0);
      checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL conc_pre_state: got %0b want 0", dup_err); end
      cyc(0, 1, 2'b00, 0, 0, 0, 0);
      checks++; if (dup_err !== 1'b1) begin errors++; $display("FAIL conc_dup_err: got %0b want 1", dup_err); end
   endtask

   task automatic test_lowest_slot();
      rst();
      for (int k = 1; k <= 3; k++) cyc(1, 0, 2'b01, OW'(k), 0, 0, 0);
      cyc(0, 0, 2'b11, 3, 2, 0, 0);
      cyc(0, 1, 2'b00, 0, 0, 0, 0);
      checks++; if (dup_slot !== 2'd1) begin errors++; $display("FAIL lowest_slot: got %0d want 1", dup_slot); end
      cyc(0, 0, 2'b01, 1, 0, 0, 0);
      cyc(0, 1, 2'b00, 0, 0, 0, 0);
      checks++; if (dup_slot !== 2'd1) begin errors++; $display("FAIL slot_frozen: got %0d want 1", dup_slot); end
      checks++; if (dup_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b want 1", dup_err); end
   endtask

   task automatic test_full();
      rst();
      for (int k = 1; k <= 4; k++) cyc(1, 0, 2'b01, OW'(k), 0, 0, 0);
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ: got %0d want 4", occupancy); end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b want 1", full); end
      cyc(1, 0, 2'b01, 9, 0, 0, 0);
      cyc(0, 0, 2'b01, 9, 0, 0, 0);
      cyc(0, 1, 2'b00, 0, 0, 0, 0);
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_drop_occ: got %0d want 4", occupancy); end
      checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL full_no_dup: got %0b want 0", dup_err); end
   endtask

   task automatic test_prior_retire();
      rst();
      cyc(0, 0, 2'b01, 2, 0, 0, 0);
      cyc(0, 0, 2'b01, 3, 0, 0, 0);
      cyc(1, 0, 2'b01, 3, 0, 0, 0);
      cyc(1, 0, 2'b00, 6, 0, 0, 0);
      cyc(0, 1, 2'b00, 0, 0, 0, 0);
      checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL prior_dup: got %0b want 0", dup_err); end
      checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL prior_occ: got %0d want 1", occupancy); end
   endtask

   task automatic test_held_trig();
      rst();
      cyc(1, 0, 2'b01, 5, 0, 0, 0);
      cyc(1, 0, 2'b01, 5, 0, 0, 0);
      checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL held_occ: got %0d want 1", occupancy); end
      cyc(0, 1, 2'b00, 0, 0, 0, 0);
      checks++; if (dup_err !== 1'b1) begin errors++; $display("FAIL held_dup: got %0b want 1", dup_err); end
   endtask

`ifdef RVFI_UNIQUE_ROLLBACK_EN
   task automatic test_rollback();
      rst();
      for (int k = 10; k <= 12; k++) cyc(1, 0, 2'b01, OW'(k), 0, 0, 0);
      cyc(0, 0, 2'b01, 11, 0, 0, 0);
      cyc(0, 0, 2'b00, 0, 0, 1, 11);
      cyc(0, 1, 2'b00, 0, 0, 0, 0);
      checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL rb_dup: got %0b want 0", dup_err); end
      checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL rb_occ: got %0d want 1", occupancy); end
      cyc(1, 0, 2'b01, 20, 0, 1, 10);
      checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL rb_cap_occ: got %0d want 1", occupancy); end
      cyc(0, 0, 2'b10, 0, 20, 0, 0);
      cyc(0, 1, 2'b00, 0, 0, 0, 0);
      cyc(0, 0, 2'b00, 0, 0, 1, 0);
      checks++; if (dup_err !== 1'b1) begin errors++; $display("FAIL rb_keeps_err: got %0b want 1", dup_err); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rb_all_occ: got %0d want 0", occupancy); end
   endtask
`endif

   task automatic test_reset_mid();
      rst();
      for (int k = 1; k <= 3; k++) cyc(1, 0, 2'b01, OW'(k), 0, 0, 0);
      cyc(0, 0, 2'b01, 2, 0, 0, 0);
      cyc(0, 1, 2'b00, 0, 0, 0, 0);
      checks++; if (dup_err !== 1'b1 || occupancy !== 3'd3) begin
         errors++; $display("FAIL mid_pre: got err=%0b occ=%0d want err=1 occ=3", dup_err, occupancy); end
      rst();
      checks++; if (dup_err !== 1'b0 || occupancy !== 3'd0 || full !== 1'b0) begin
         errors++; $display("FAIL mid_reset: got err=%0b occ=%0d full=%0b want 0 0 0", dup_err, occupancy, full); end
   endtask

   task automatic test_random();
      int eo;
      logic rv;
      rst();
      for (int n = 0; n < 800; n++) begin
         if (n % 50 == 49) rst();
         rv = 0;
`ifdef RVFI_UNIQUE_ROLLBACK_EN
         rv = $urandom_range(0, 9) == 0;
`endif
         cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
             OW'($urandom_range(0, 7)), OW'($urandom_range(0, 7)), rv, OW'($urandom_range(0, 8)));
         eo = 0;
         for (int i = 0; i < DEPTH; i++) eo += int'(m_vld[i]);
         checks++; if (occupancy !== 3'(eo) || full !== (eo == DEPTH)) begin
            errors++; $display("FAIL rand_occ@%0d: got occ=%0d full=%0b want occ=%0d", n, occupancy, full, eo); end
         checks++; if (dup_err !== m_err || (m_err && dup_slot !== 2'(m_slot))) begin
            errors++; $display("FAIL rand_dup@%0d: got err=%0b slot=%0d want err=%0b slot=%0d", n, dup_err, dup_slot, m_err, m_slot); end
      end
   endtask

   initial begin
      reset = 1; trig = 0; check = 0; rvfi_valid = '0; rvfi_order = '0; rb_v = 0; rb_o = '0;
      model_clear();
      test_reset();
      test_single_dup();
      test_concurrent();
      test_lowest_slot();
      test_full();
      test_prior_retire();
      test_held_trig();
`ifdef RVFI_UNIQUE_ROLLBACK_EN
      test_rollback();
`endif
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
